adc_capture_sequencer: RTL and testbench
========================================

# adc_capture_sequencer

Single-clock sequencer that drives the `adc_driver` control interface on behalf of the PL. On each accepted capture command it:
- serially programs the run-cycle count and the accumulate shift value;
- fires 2^shift triggers;
- reprograms shift to 0 so the driver's accumulated result becomes readable.

It owns `gpio_ctrl` and the driver's `select_in`, so the CPU no longer needs to bit-bang those lines.

## Interface
Parameters:
- `CFG_W`, default `config_reg_width`: width of each serial config register.
- `GPIO_W`, default 16: width of `gpio_ctrl`.
- `PHASE_CYC`, default 2: cycles per serial phase (setup, strobe high, strobe low). Must be ≥1.
- `TRIG_GAP`, default 50: idle cycles after each trigger pulse.

Ports:
- `pl_clk`, in, 1: sole clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `cmd_valid`, in, 1: capture command offered.
- `cmd_ready`, out, 1: high only in IDLE.
- `cmd_run_cycles`, in, `CFG_W`: value written to the run-cycle register.
- `cmd_shift`, in, 4: accumulate shift. Trigger count is 2^`cmd_shift`, from 1 to 32768.
- `abort`, in, 1: cancel the sequence in progress.
- `gpio_ctrl`, out, `GPIO_W`: driven only on bits `sdata`, `trigger_line`, `adc_num_cycle_count_clk` and `adc_shift_val_clk`. All other bits are 0.
- `select_out`, out, 1: connects to the driver's `select_in`.
- `busy`, out, 1: high whenever the state is not IDLE.
- `done`, out, 1: one-cycle pulse when a sequence completes.

## Operation
States: IDLE, SEL_PRE, SHIFT_BIT, SEL_POST, TRIG, GAP, DONE. A 2-bit phase register selects the register being written: CYC, SHIFT, CLR.

- **IDLE.** Asserts `cmd_ready`. When `cmd_valid` is high, latches `cmd_run_cycles` and `cmd_shift`, sets the phase to CYC, and moves to SEL_PRE.
- **SEL_PRE.** Lasts 1 cycle. `select_out`=1 and all gpio bits are 0.
- **SHIFT_BIT.** Shifts `CFG_W` bits out, LSB first. Each bit takes 3×`PHASE_CYC` cycles:
  - `sdata`=bit for the whole bit period;
  - the target strobe is low for `PHASE_CYC` cycles, high for `PHASE_CYC` cycles, then low for `PHASE_CYC` cycles.
  - The target strobe is `adc_num_cycle_count_clk` in phase CYC and `adc_shift_val_clk` in phases SHIFT and CLR.
- **SEL_POST.** Lasts 1 cycle with `select_out`=1 and `sdata` cleared. `select_out` drops on the following cycle. Next state:
  - phase CYC: go to SEL_PRE with phase SHIFT;
  - phase SHIFT: go to TRIG;
  - phase CLR: go to DONE.
- **TRIG.** Lasts 1 cycle with `gpio_ctrl[trigger_line]`=1. Increments the 16-bit trigger counter, then goes to GAP.
- **GAP.** Lasts `TRIG_GAP` cycles. Afterwards:
  - if the counter equals 2^shift, go to SEL_PRE with phase CLR and data 0;
  - otherwise go back to TRIG.
- **DONE.** Lasts 1 cycle with `done`=1, then returns to IDLE.

Boundary conditions:
- `cmd_shift`=0 gives exactly one trigger.
- A `cmd_valid` asserted while busy is not accepted and has no effect.
- `abort`, in any non-IDLE state:
  - gpio and `select_out` drop to 0 on the next edge;
  - the state returns to IDLE with no `done` pulse;
  - the driver registers are left partially written, and the host must issue a new command.
- `abort` in IDLE is ignored. When `abort` and `cmd_valid` are both high in IDLE, the command is accepted.
- Reset mid-sequence behaves like abort, but takes effect asynchronously.

## Timing
- Every output is registered. Reset values: `gpio_ctrl`=0, `select_out`=0, `busy`=0, `done`=0, `cmd_ready`=1.
- Accept edge to first `select_out` high: 1 cycle.
- One register write = `CFG_W`×3×`PHASE_CYC` + 2 cycles, select-high span.
- Total latency = 3 writes + 3 select-low gaps + 2^shift × (1 + `TRIG_GAP`) + 1 (DONE).
- The `sdata` change never coincides with a strobe edge: it leads the rising strobe by `PHASE_CYC` cycles.

## Configuration
- `ADC_SEQ_RUN_COUNT_EN`
  - **Defined:** adds output `run_count` (32-bit) that increments on every `done` pulse, wraps at 2^32−1→0, and resets to 0.
  - **Undefined:** the port and counter are absent, and all other behaviour is identical.

## Structure
- Add to `rfsoc_config`:
  - the state enum `adc_seq_state_t`;
  - the phase enum `adc_seq_phase_t`.
- Reuse the existing gpio bit constants from `rfsoc_config`.
- One sub-module: `serial_cfg_writer`, which implements SEL_PRE/SHIFT_BIT/SEL_POST with a start/done handshake and a strobe-select input. The top FSM reuses it for all three writes.

## Test plan
Default parameters throughout (`PHASE_CYC`=2, `TRIG_GAP`=50).
- **Basic sequence.** Reset, then a command with run_cycles=4 and shift=2.
  - `adc_num_cycle_count_clk` shows `CFG_W` rising edges with sampled `sdata` = 4, LSB first.
  - `adc_shift_val_clk` shows `CFG_W` edges encoding 2.
  - Exactly 4 trigger pulses, 51 cycles apart.
  - A final shift write encodes 0, followed by one `done` pulse.
- **Shift 0.** run_cycles=1, shift=0 → exactly 1 trigger, then `done`. The total cycle count matches the latency formula.
- **Command while busy.** `cmd_valid` held high for the whole sequence → `cmd_ready` is low while busy. The second command is accepted exactly 1 cycle after `done`.
- **Abort mid-trigger.** Assert `abort` during the 3rd GAP → all outputs are 0 on the next cycle, no `done`, and `cmd_ready` is 1.
- **Reset mid-write.** Assert `rst` low during SHIFT_BIT → outputs go to 0 immediately (asynchronously). After release, the block is IDLE.
- **Run counter.** With `ADC_SEQ_RUN_COUNT_EN` defined, run 3 sequences → `run_count`=3. Reset → 0.

Source files
------------

// File: rtl/adc_capture_sequencer_pkg.sv
// Shared RFSoC configuration: serial config width, gpio bit map and the
// capture-sequencer state/phase encodings.
package rfsoc_config;

   localparam int config_reg_width        = 16;

   localparam int sdata                   = 0;
   localparam int trigger_line            = 1;
   localparam int adc_num_cycle_count_clk = 2;
   localparam int adc_shift_val_clk       = 3;

   typedef enum logic [2:0] {
      IDLE, SEL_PRE, SHIFT_BIT, SEL_POST, TRIG, GAP, DONE
   } adc_seq_state_t;

   typedef enum logic [1:0] {
      CYC, SHIFT, CLR
   } adc_seq_phase_t;

endpackage

// File: rtl/adc_capture_sequencer_serial_cfg_writer.sv
// One serial register write to the adc_driver: select frame, CFG_W bits LSB
// first with a centred strobe, then a one-cycle wr_done after select drops.
module serial_cfg_writer
   import rfsoc_config::*;
#(
   parameter int CFG_W     = config_reg_width,
   parameter int PHASE_CYC = 2
) (
   input  logic             pl_clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             strobe_sel,
   input  logic [CFG_W-1:0] data,
   output logic             select_out,
   output logic             ser_data,
   output logic             strobe_cyc,
   output logic             strobe_shift,
   output logic             wr_done
);

   localparam int SUB_W = (3*PHASE_CYC > 1) ? $clog2(3*PHASE_CYC) : 1;
   localparam int BIT_W = (CFG_W > 1) ? $clog2(CFG_W) : 1;
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(3*PHASE_CYC - 1);
   localparam logic [SUB_W-1:0] STB_ON   = SUB_W'(PHASE_CYC);
   localparam logic [SUB_W-1:0] STB_OFF  = SUB_W'(2*PHASE_CYC);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_W - 1);

   adc_seq_state_t   state_q, n_state;
   logic [SUB_W-1:0] sub_q, n_sub;
   logic [BIT_W-1:0] bit_q, n_bit;
   logic [CFG_W-1:0] data_q, n_data;
   logic             sel_q, n_sel;
   logic             n_done, n_select, n_sdata, n_strobe;

   always_comb begin
      n_state = state_q;
      n_sub   = sub_q;
      n_bit   = bit_q;
      n_data  = data_q;
      n_sel   = sel_q;
      n_done  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            n_state = SEL_PRE;
            n_data  = data;
            n_sel   = strobe_sel;
         end
         SEL_PRE: begin
            n_state = SHIFT_BIT;
            n_sub   = '0;
            n_bit   = '0;
         end
         SHIFT_BIT: if (sub_q == SUB_LAST) begin
            n_sub = '0;
            if (bit_q == BIT_LAST) n_state = SEL_POST;
            else                   n_bit   = bit_q + 1'b1;
         end else begin
            n_sub = sub_q + 1'b1;
         end
         SEL_POST: begin
            n_state = IDLE;
            n_done  = 1'b1;
         end
         default: n_state = IDLE;
      endcase
      if (abort) begin
         n_state = IDLE;
         n_done  = 1'b0;
      end
      n_select = (n_state == SEL_PRE) || (n_state == SHIFT_BIT) || (n_state == SEL_POST);
      n_sdata  = (n_state == SHIFT_BIT) && n_data[n_bit];
      // strobe sits in the middle third of each bit so sdata is settled on both edges
      n_strobe = (n_state == SHIFT_BIT) && (n_sub >= STB_ON) && (n_sub < STB_OFF);
   end

   always_ff @(posedge pl_clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         sub_q        <= '0;
         bit_q        <= '0;
         data_q       <= '0;
         sel_q        <= 1'b0;
         select_out   <= 1'b0;
         ser_data     <= 1'b0;
         strobe_cyc   <= 1'b0;
         strobe_shift <= 1'b0;
         wr_done      <= 1'b0;
      end else begin
         state_q      <= n_state;
         sub_q        <= n_sub;
         bit_q        <= n_bit;
         data_q       <= n_data;
         sel_q        <= n_sel;
         select_out   <= n_select;
         ser_data     <= n_sdata;
         strobe_cyc   <= n_strobe && !n_sel;
         strobe_shift <= n_strobe && n_sel;
         wr_done      <= n_done;
      end
   end

endmodule

// File: rtl/adc_capture_sequencer.sv
// Capture sequencer: programs run cycles and shift, fires 2^shift triggers,
// then clears shift. Optional run_count output under ADC_SEQ_RUN_COUNT_EN.
module adc_capture_sequencer
   import rfsoc_config::*;
#(
   parameter int CFG_W     = config_reg_width,
   parameter int GPIO_W    = 16,
   parameter int PHASE_CYC = 2,
   parameter int TRIG_GAP  = 50
) (
   input  logic              pl_clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CFG_W-1:0]  cmd_run_cycles,
   input  logic [3:0]        cmd_shift,
   input  logic              abort,
   output logic [GPIO_W-1:0] gpio_ctrl,
   output logic              select_out,
   output logic              busy,
   output logic              done
`ifdef ADC_SEQ_RUN_COUNT_EN
   ,
   output logic [31:0]       run_count
`endif
);

   localparam int GAP_W = (TRIG_GAP > 1) ? $clog2(TRIG_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TRIG_GAP - 1);

   // SEL_PRE in this FSM covers the whole delegated write plus its trailing select-low cycle
   adc_seq_state_t   state_q, n_state;
   adc_seq_phase_t   phase_q, n_phase;
   logic [3:0]       shift_q, n_shift;
   logic [15:0]      cnt_q, n_cnt;
   logic [GAP_W-1:0] gap_q, n_gap;
   logic             trig_q;
   logic             wr_start, wr_sel, wr_abort, wr_done;
   logic [CFG_W-1:0] wr_data;
   logic             w_sdata, w_stb_cyc, w_stb_shift;
   logic [15:0]      target;

   assign target   = 16'd1 << shift_q;
   assign wr_abort = abort && (state_q != IDLE);

   always_comb begin
      n_state  = state_q;
      n_phase  = phase_q;
      n_shift  = shift_q;
      n_cnt    = cnt_q;
      n_gap    = gap_q;
      wr_start = 1'b0;
      wr_sel   = 1'b0;
      wr_data  = '0;
      case (state_q)
         IDLE: if (cmd_valid) begin
            n_state  = SEL_PRE;
            n_phase  = CYC;
            n_shift  = cmd_shift;
            n_cnt    = '0;
            wr_start = 1'b1;
            wr_data  = cmd_run_cycles;
         end
         SEL_PRE: if (wr_done) begin
            case (phase_q)
               CYC: begin
                  n_phase  = SHIFT;
                  wr_start = 1'b1;
                  wr_sel   = 1'b1;
                  wr_data  = CFG_W'(shift_q);
               end
               SHIFT:   n_state = TRIG;
               default: n_state = DONE;
            endcase
         end
         TRIG: begin
            n_state = GAP;
            n_cnt   = cnt_q + 16'd1;
            n_gap   = '0;
         end
         GAP: if (gap_q == GAP_LAST) begin
            if (cnt_q == target) begin
               n_state  = SEL_PRE;
               n_phase  = CLR;
               wr_start = 1'b1;
               wr_sel   = 1'b1;
            end else begin
               n_state = TRIG;
            end
         end else begin
            n_gap = gap_q + 1'b1;
         end
         DONE:    n_state = IDLE;
         default: n_state = IDLE;
      endcase
      if (wr_abort) begin
         n_state  = IDLE;
         wr_start = 1'b0;
      end
   end

   always_ff @(posedge pl_clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         phase_q   <= CYC;
         shift_q   <= '0;
         cnt_q     <= '0;
         gap_q     <= '0;
         trig_q    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cmd_ready <= 1'b1;
      end else begin
         state_q   <= n_state;
         phase_q   <= n_phase;
         shift_q   <= n_shift;
         cnt_q     <= n_cnt;
         gap_q     <= n_gap;
         trig_q    <= (n_state == TRIG);
         busy      <= (n_state != IDLE);
         done      <= (n_state == DONE);
         cmd_ready <= (n_state == IDLE);
      end
   end

`ifdef ADC_SEQ_RUN_COUNT_EN
   always_ff @(posedge pl_clk or negedge rst) begin
      if (!rst)                  run_count <= '0;
      else if (n_state == DONE)  run_count <= run_count + 32'd1;
   end
`endif

   serial_cfg_writer #(
      .CFG_W     (CFG_W),
      .PHASE_CYC (PHASE_CYC)
   ) u_writer (
      .pl_clk       (pl_clk),
      .rst          (rst),
      .start        (wr_start),
      .abort        (wr_abort),
      .strobe_sel   (wr_sel),
      .data         (wr_data),
      .select_out   (select_out),
      .ser_data     (w_sdata),
      .strobe_cyc   (w_stb_cyc),
      .strobe_shift (w_stb_shift),
      .wr_done      (wr_done)
   );

   always_comb begin
      gpio_ctrl                          = '0;
      gpio_ctrl[sdata]                   = w_sdata;
      gpio_ctrl[trigger_line]            = trig_q;
      gpio_ctrl[adc_num_cycle_count_clk] = w_stb_cyc;
      gpio_ctrl[adc_shift_val_clk]       = w_stb_shift;
   end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Bench for adc_capture_sequencer: decodes the serial protocol from gpio and
// compares against values derived from the command and the latency formula.
`timescale 1ns/1ps
module tb_adc_capture_sequencer;
   import rfsoc_config::*;

   localparam int CFG_W     = config_reg_width;
   localparam int GPIO_W    = 16;
   localparam int PHASE_CYC = 2;
   localparam int TRIG_GAP  = 50;
   localparam int WR_SPAN   = CFG_W*3*PHASE_CYC + 2;

   logic              pl_clk = 1'b0;
   logic              rst = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              abort = 1'b0;
   logic [CFG_W-1:0]  cmd_run_cycles = '0;
   logic [3:0]        cmd_shift = '0;
   logic              cmd_ready, busy, done, select_out;
   logic [GPIO_W-1:0] gpio_ctrl;
`ifdef ADC_SEQ_RUN_COUNT_EN
   logic [31:0]       run_count;
`endif

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int proto_err = 0;
   int cyc_bits[$], sft_bits[$], trig_times[$], done_times[$], sel_rise[$];

   adc_capture_sequencer #(
      .CFG_W(CFG_W), .GPIO_W(GPIO_W), .PHASE_CYC(PHASE_CYC), .TRIG_GAP(TRIG_GAP)
   ) dut (
      .pl_clk(pl_clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_run_cycles(cmd_run_cycles), .cmd_shift(cmd_shift), .abort(abort),
      .gpio_ctrl(gpio_ctrl), .select_out(select_out), .busy(busy), .done(done)
`ifdef ADC_SEQ_RUN_COUNT_EN
      , .run_count(run_count)
`endif
   );

   always #5 pl_clk = ~pl_clk;
   always @(posedge pl_clk) cyc <= cyc + 1;

   // protocol monitor, sampled mid-cycle
   logic p_nc = 0, p_sv = 0, p_tr = 0, p_sel = 0, p_sd = 0;
   int   sd_stable = 0;
   always @(negedge pl_clk) begin
      if (gpio_ctrl[sdata] != p_sd || (select_out && !p_sel)) sd_stable = 1;
      else sd_stable++;
      if (gpio_ctrl[adc_num_cycle_count_clk] && !p_nc) begin
         cyc_bits.push_back(int'(gpio_ctrl[sdata]));
         if (!select_out || sd_stable < PHASE_CYC + 1) proto_err++;
      end
      if (gpio_ctrl[adc_shift_val_clk] && !p_sv) begin
         sft_bits.push_back(int'(gpio_ctrl[sdata]));
         if (!select_out || sd_stable < PHASE_CYC + 1) proto_err++;
      end
      if ((gpio_ctrl[adc_num_cycle_count_clk] || gpio_ctrl[adc_shift_val_clk]) && gpio_ctrl[sdata] != p_sd)
         proto_err++;
      if ((gpio_ctrl & ~GPIO_W'(16'h000F)) != '0) proto_err++;
      if (gpio_ctrl[trigger_line] && !p_tr) trig_times.push_back(cyc);
      if (done) done_times.push_back(cyc);
      if (select_out && !p_sel) sel_rise.push_back(cyc);
      p_nc  = gpio_ctrl[adc_num_cycle_count_clk];
      p_sv  = gpio_ctrl[adc_shift_val_clk];
      p_tr  = gpio_ctrl[trigger_line];
      p_sel = select_out;
      p_sd  = gpio_ctrl[sdata];
   end

   function automatic int lat(input int sh);
      return 3*WR_SPAN + 3 + (1 << sh)*(1 + TRIG_GAP) + 1;
   endfunction

   function automatic int decode(input bit from_shift, input int off);
      logic [31:0] v;
      int b;
      v = '0;
      for (int i = 0; i < CFG_W; i++) begin
         b = 0;
         if (from_shift) begin
            if (off + i < sft_bits.size()) b = sft_bits[off + i];
         end else begin
            if (off + i < cyc_bits.size()) b = cyc_bits[off + i];
         end
         if (b != 0) v[i] = 1'b1;
      end
      return int'(v);
   endfunction

   function automatic int first_of(input int which);
      case (which)
         0: return (sel_rise.size()   > 0) ? sel_rise[0]   : -1;
         1: return (trig_times.size() > 0) ? trig_times[0] : -1;
         default: return (done_times.size() > 0) ? done_times[0] : -1;
      endcase
   endfunction

   task automatic clear_mon();
      cyc_bits.delete(); sft_bits.delete(); trig_times.delete();
      done_times.delete(); sel_rise.delete(); proto_err = 0;
   endtask

   task automatic do_seq(input int run_c, input int sh, output int acc, output bit timeout);
      @(negedge pl_clk);
      clear_mon();
      cmd_run_cycles = CFG_W'(run_c);
      cmd_shift      = 4'(sh);
      cmd_valid      = 1'b1;
      acc            = cyc + 1;
      @(negedge pl_clk);
      cmd_valid = 1'b0;
      timeout   = 1'b1;
      repeat (lat(sh) + 20) begin
         if (done_times.size() != 0) begin
            timeout = 1'b0;
            break;
         end
         @(negedge pl_clk);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge pl_clk);
      checks++; if (gpio_ctrl !== '0) begin errors++; $display("FAIL rst_gpio: got %0h expected 0", gpio_ctrl); end
      checks++; if (select_out !== 1'b0) begin errors++; $display("FAIL rst_select: got %0b expected 0", select_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b expected 0", done); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b expected 1", cmd_ready); end
      rst = 1'b1;
      @(negedge pl_clk);
      checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_rst_idle: ready=%0b busy=%0b expected 1/0", cmd_ready, busy); end
   endtask

   task automatic test_basic();
      int a, bad; bit to;
      do_seq(4, 2, a, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %0b expected 0", to); end
      checks++; if (first_of(0) !== a) begin errors++; $display("FAIL basic_sel_rise: got %0d expected %0d", first_of(0), a); end
      checks++; if (cyc_bits.size() !== CFG_W) begin errors++; $display("FAIL basic_cyc_edges: got %0d expected %0d", cyc_bits.size(), CFG_W); end
      checks++; if (decode(1'b0, 0) !== 4) begin errors++; $display("FAIL basic_cyc_val: got %0d expected 4", decode(1'b0, 0)); end
      checks++; if (sft_bits.size() !== 2*CFG_W) begin errors++; $display("FAIL basic_sft_edges: got %0d expected %0d", sft_bits.size(), 2*CFG_W); end
      checks++; if (decode(1'b1, 0) !== 2) begin errors++; $display("FAIL basic_sft_val: got %0d expected 2", decode(1'b1, 0)); end
      checks++; if (decode(1'b1, CFG_W) !== 0) begin errors++; $display("FAIL basic_clr_val: got %0d expected 0", decode(1'b1, CFG_W)); end
      checks++; if (trig_times.size() !== 4) begin errors++; $display("FAIL basic_trig_cnt: got %0d expected 4", trig_times.size()); end
      checks++; if (first_of(1) !== a + 2*WR_SPAN + 2) begin errors++; $display("FAIL basic_trig0: got %0d expected %0d", first_of(1), a + 2*WR_SPAN + 2); end
      bad = 0;
      for (int i = 1; i < trig_times.size(); i++)
         if (trig_times[i] - trig_times[i-1] != 1 + TRIG_GAP) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL basic_trig_spacing: got %0d bad gaps expected 0", bad); end
      checks++; if (done_times.size() !== 1) begin errors++; $display("FAIL basic_done_cnt: got %0d expected 1", done_times.size()); end
      checks++; if (first_of(2) - a + 1 !== lat(2)) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", first_of(2) - a + 1, lat(2)); end
      checks++; if (sel_rise.size() !== 3) begin errors++; $display("FAIL basic_writes: got %0d expected 3", sel_rise.size()); end
      checks++; if (proto_err !== 0) begin errors++; $display("FAIL basic_protocol: got %0d errors expected 0", proto_err); end
   endtask

   task automatic test_shift0();
      int a; bit to;
      do_seq(1, 0, a, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL s0_timeout: got %0b expected 0", to); end
      checks++; if (trig_times.size() !== 1) begin errors++; $display("FAIL s0_trig_cnt: got %0d expected 1", trig_times.size()); end
      checks++; if (decode(1'b0, 0) !== 1) begin errors++; $display("FAIL s0_cyc_val: got %0d expected 1", decode(1'b0, 0)); end
      checks++; if (first_of(2) - a + 1 !== lat(0)) begin errors++; $display("FAIL s0_latency: got %0d expected %0d", first_of(2) - a + 1, lat(0)); end
   endtask

   task automatic test_back_to_back();
      int a, l, bad;
      @(negedge pl_clk);
      clear_mon();
      cmd_run_cycles = CFG_W'(3);
      cmd_shift      = 4'd1;
      cmd_valid      = 1'b1;
      a = cyc + 1;
      l = lat(1);
      bad = 0;
      for (int k = 0; k < l; k++) begin
         @(negedge pl_clk);
         if (cmd_ready !== 1'b0 || busy !== 1'b1) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_ready_low: got %0d bad cycles expected 0", bad); end
      @(negedge pl_clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_gap: got %0b expected 1", cmd_ready); end
      checks++; if (first_of(2) !== a + l - 1) begin errors++; $display("FAIL b2b_done1: got %0d expected %0d", first_of(2), a + l - 1); end
      @(negedge pl_clk);
      checks++; if (select_out !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_accept2: sel=%0b busy=%0b expected 1/1", select_out, busy); end
      cmd_valid = 1'b0;
      repeat (l + 20) begin
         if (done_times.size() >= 2) break;
         @(negedge pl_clk);
      end
      checks++; if (done_times.size() !== 2 || done_times[done_times.size()-1] !== a + 2*l) begin
         errors++; $display("FAIL b2b_done2: got %0d pulses expected 2 with last at %0d", done_times.size(), a + 2*l);
      end
   endtask

   task automatic test_abort();
      int a, t3; bit to;
      @(negedge pl_clk);
      clear_mon();
      cmd_run_cycles = CFG_W'(5);
      cmd_shift      = 4'd2;
      cmd_valid      = 1'b1;
      a = cyc + 1;
      @(negedge pl_clk);
      cmd_valid = 1'b0;
      t3 = a + 2*WR_SPAN + 2 + 2*(1 + TRIG_GAP);
      while (cyc < t3 + 10) @(negedge pl_clk);
      abort = 1'b1;
      @(negedge pl_clk);
      abort = 1'b0;
      checks++; if (gpio_ctrl !== '0 || select_out !== 1'b0) begin errors++; $display("FAIL abort_outputs: gpio=%0h sel=%0b expected 0/0", gpio_ctrl, select_out); end
      checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_idle: busy=%0b ready=%0b expected 0/1", busy, cmd_ready); end
      repeat (100) @(negedge pl_clk);
      checks++; if (done_times.size() !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", done_times.size()); end
      checks++; if (trig_times.size() !== 3) begin errors++; $display("FAIL abort_trig_cnt: got %0d expected 3", trig_times.size()); end
      // abort alone in IDLE is ignored; abort with cmd_valid still accepts
      abort = 1'b1;
      @(negedge pl_clk);
      checks++; if (busy !== 1'b0 || select_out !== 1'b0) begin errors++; $display("FAIL abort_idle_ignored: busy=%0b sel=%0b expected 0/0", busy, select_out); end
      clear_mon();
      cmd_run_cycles = CFG_W'(9);
      cmd_shift      = 4'd0;
      cmd_valid      = 1'b1;
      a = cyc + 1;
      @(negedge pl_clk);
      abort = 1'b0;
      cmd_valid = 1'b0;
      checks++; if (select_out !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL abort_valid_accept: sel=%0b busy=%0b expected 1/1", select_out, busy); end
      to = 1'b1;
      repeat (lat(0) + 20) begin
         if (done_times.size() != 0) begin to = 1'b0; break; end
         @(negedge pl_clk);
      end
      checks++; if (to !== 1'b0 || first_of(2) - a + 1 !== lat(0)) begin errors++; $display("FAIL abort_valid_latency: got %0d expected %0d", first_of(2) - a + 1, lat(0)); end
   endtask

   task automatic test_reset_mid();
      int a;
      @(negedge pl_clk);
      clear_mon();
      cmd_run_cycles = CFG_W'(16'hA5A5);
      cmd_shift      = 4'd1;
      cmd_valid      = 1'b1;
      a = cyc + 1;
      @(negedge pl_clk);
      cmd_valid = 1'b0;
      while (cyc < a + 3) @(negedge pl_clk);
      checks++; if (gpio_ctrl[adc_num_cycle_count_clk] !== 1'b1 || gpio_ctrl[sdata] !== 1'b1) begin
         errors++; $display("FAIL rmid_pre_strobe: gpio=%0h expected strobe and sdata high", gpio_ctrl);
      end
      #2 rst = 1'b0;
      #1;
      checks++; if (gpio_ctrl !== '0 || select_out !== 1'b0) begin errors++; $display("FAIL rmid_async_out: gpio=%0h sel=%0b expected 0/0", gpio_ctrl, select_out); end
      checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rmid_async_ctl: busy=%0b ready=%0b done=%0b expected 0/1/0", busy, cmd_ready, done); end
      @(negedge pl_clk);
      rst = 1'b1;
      repeat (2) @(negedge pl_clk);
      checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || select_out !== 1'b0) begin errors++; $display("FAIL rmid_idle_after: busy=%0b ready=%0b sel=%0b expected 0/1/0", busy, cmd_ready, select_out); end
   endtask

   task automatic test_random();
      int a, rc, sh, bad; bit to;
      for (int n = 0; n < 4; n++) begin
         rc = int'($urandom_range(0, (1 << CFG_W) - 1));
         sh = int'($urandom_range(0, 3));
         do_seq(rc, sh, a, to);
         bad = 0;
         if (to) bad++;
         if (decode(1'b0, 0) != rc) bad++;
         if (decode(1'b1, 0) != sh) bad++;
         if (decode(1'b1, CFG_W) != 0) bad++;
         if (trig_times.size() != (1 << sh)) bad++;
         if (first_of(2) - a + 1 != lat(sh)) bad++;
         if (proto_err != 0) bad++;
         checks++; if (bad !== 0) begin
            errors++;
            $display("FAIL random_seq: run=%0d shift=%0d got cyc=%0d sft=%0d trig=%0d lat=%0d expected trig=%0d lat=%0d",
                     rc, sh, decode(1'b0, 0), decode(1'b1, 0), trig_times.size(), first_of(2) - a + 1, 1 << sh, lat(sh));
         end
      end
   endtask

`ifdef ADC_SEQ_RUN_COUNT_EN
   task automatic test_run_count();
      int a; bit to;
      @(negedge pl_clk);
      rst = 1'b0;
      @(negedge pl_clk);
      rst = 1'b1;
      checks++; if (run_count !== 32'd0) begin errors++; $display("FAIL rc_start: got %0d expected 0", run_count); end
      repeat (3) do_seq(7, 0, a, to);
      @(negedge pl_clk);
      checks++; if (run_count !== 32'd3) begin errors++; $display("FAIL rc_three: got %0d expected 3", run_count); end
      rst = 1'b0;
      #1;
      checks++; if (run_count !== 32'd0) begin errors++; $display("FAIL rc_reset: got %0d expected 0", run_count); end
      @(negedge pl_clk);
      rst = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_shift0();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_random();
`ifdef ADC_SEQ_RUN_COUNT_EN
      test_run_count();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
